// File: rtl/mem_responder_if.sv
// Memory port between the core (master) and the memory responder (slave).
// Handshake: the master raises cs with we and/or oe for a request and the slave
// latches it on the accepting edge. Inputs are ignored until ram_ready pulses.
interface mem_responder_if;
   logic        cs;
   logic        we;
   logic        oe;
   logic [31:0] address;
   logic [1:0]  data_size;
   logic [31:0] ram_data_in;
   logic [31:0] ram_data_into_mcu;
   logic        ram_ready;
   logic        err;

   modport master (
      output cs, we, oe, address, data_size, ram_data_in,
      input  ram_data_into_mcu, ram_ready, err
   );

   modport slave (
      input  cs, we, oe, address, data_size, ram_data_in,
      output ram_data_into_mcu, ram_ready, err
   );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM responder with programmable wait states, byte/halfword/word
// lanes and illegal-access reporting on err alongside the ram_ready pulse.
module mem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic             clk,
   input  logic             rst,
   mem_responder_if.slave   bus,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   localparam bit ZERO_WAIT = (WAIT_STATES == 0);

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        we_q;
   logic        oe_q;
   logic [31:0] wdata_q;
   logic        ready_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

   logic                  req;
   logic [31:0]           cur_addr;
   logic [1:0]            cur_size;
   logic                  cur_we;
   logic                  cur_oe;
   logic [31:0]           cur_wdata;
   logic                  resp_edge;
   logic                  illegal;
   logic                  do_write;
   logic [ADDR_WIDTH-1:0] widx;
   logic [31:0]           rword;
   logic [31:0]           rshift;
   logic [31:0]           rdata;
   logic [3:0]            be;
   logic [31:0]           wd;
   logic [31:0]           merged;

   // In IDLE with zero wait states the response edge is the acceptance edge,
   // so the live inputs stand in for the latched request.
   always_comb begin
      req       = bus.cs & (bus.we | bus.oe);
      cur_addr  = addr_q;
      cur_size  = size_q;
      cur_we    = we_q;
      cur_oe    = oe_q;
      cur_wdata = wdata_q;
      if (state == IDLE) begin
         cur_addr  = bus.address;
         cur_size  = bus.data_size;
         cur_we    = bus.we;
         cur_oe    = bus.oe;
         cur_wdata = bus.ram_data_in;
      end

      resp_edge = (state == IDLE && req && ZERO_WAIT) || (state == WAIT && cnt == 4'd0);

      illegal = (cur_we & cur_oe)
              | (cur_size == 2'b11)
              | ((cur_size == 2'b01) & cur_addr[0])
              | ((cur_size == 2'b10) & (|cur_addr[1:0]))
              | (|(cur_addr >> (ADDR_WIDTH + 2)));

      do_write = rst & resp_edge & cur_we & ~illegal;

      widx   = cur_addr[ADDR_WIDTH+1:2];
      rword  = mem[widx];
      rshift = rword >> {cur_addr[1:0], 3'b000};

      be = 4'b0000;
      wd = cur_wdata;
      case (cur_size)
         2'b00: begin
            be = 4'b0001 << cur_addr[1:0];
            wd = {4{cur_wdata[7:0]}};
         end
         2'b01: begin
            be = cur_addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{cur_wdata[15:0]}};
         end
         2'b10: be = 4'b1111;
         default: be = 4'b0000;
      endcase

      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be[i] ? wd[8*i +: 8] : rword[8*i +: 8];
      end

      case (cur_size)
         2'b00:   rdata = {24'b0, rshift[7:0]};
         2'b01:   rdata = {16'b0, rshift[15:0]};
         default: rdata = rshift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[widx] <= merged;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         addr_q  <= 32'd0;
         size_q  <= 2'd0;
         we_q    <= 1'b0;
         oe_q    <= 1'b0;
         wdata_q <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         ready_q <= resp_edge;
         err_q   <= resp_edge & illegal;
         if (resp_edge && (illegal || cur_oe)) begin
            rdata_q <= illegal ? 32'd0 : rdata;
         end
         case (state)
            IDLE: begin
               if (req) begin
                  addr_q  <= bus.address;
                  size_q  <= bus.data_size;
                  we_q    <= bus.we;
                  oe_q    <= bus.oe;
                  wdata_q <= bus.ram_data_in;
                  if (ZERO_WAIT) begin
                     state <= RESP;
                  end else begin
                     cnt   <= 4'(WAIT_STATES - 1);
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ram_ready         = ready_q;
   assign bus.err               = err_q;
   assign bus.ram_data_into_mcu = rdata_q;
   assign state_dbg             = state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized accesses checked
// against a byte-array model of memory and the access legality rules.
module tb_mem_responder;

   logic       clk;
   logic       rst;
   logic       rst0;
   logic [1:0] state_dbg;
   logic [1:0] state_dbg0;

   mem_responder_if bus ();
   mem_responder_if bus0 ();

   mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
      .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
   );

   mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst0), .bus(bus0), .state_dbg(state_dbg0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  model_mem [0:63];
   logic [31:0] last_data = 32'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_legal(bit we, bit oe, logic [31:0] addr, logic [1:0] size);
      int nbytes;
      nbytes = 1 << size;
      if (we && oe) return 1'b0;
      if (size == 2'b11) return 1'b0;
      if ((addr % nbytes) != 0) return 1'b0;
      if (addr >= 32'd4096) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_access(input bit we, input bit oe, input logic [31:0] addr,
                               input logic [1:0] size, input logic [31:0] wdata,
                               output logic [31:0] exp_data, output bit exp_err);
      int nbytes;
      logic [31:0] val;
      nbytes  = 1 << size;
      exp_err = !is_legal(we, oe, addr, size);
      if (exp_err) begin
         last_data = 32'd0;
      end else if (we) begin
         for (int i = 0; i < nbytes; i++) model_mem[addr + i] = wdata[8*i +: 8];
      end else begin
         val = 32'd0;
         for (int i = 0; i < nbytes; i++) val = val | (32'(model_mem[addr + i]) << (8 * i));
         last_data = val;
      end
      exp_data = last_data;
   endtask

   task automatic scramble();
      bus.cs          = 1'b0;
      bus.we          = 1'($urandom);
      bus.oe          = 1'($urandom);
      bus.address     = $urandom;
      bus.data_size   = 2'($urandom);
      bus.ram_data_in = $urandom;
   endtask

   task automatic run_access(input string tag, input bit we, input bit oe,
                             input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata, output logic [31:0] obs);
      logic [31:0] exp_d;
      bit exp_e;
      bit got;
      int lat;
      model_access(we, oe, addr, size, wdata, exp_d, exp_e);
      @(negedge clk);
      bus.cs = 1'b1; bus.we = we; bus.oe = oe;
      bus.address = addr; bus.data_size = size; bus.ram_data_in = wdata;
      @(posedge clk);
      #1 scramble();
      got = 1'b0;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (bus.ram_ready) begin
            got = 1'b1;
            lat = c;
            break;
         end
         scramble();
      end
      check({tag, "_ready"}, 32'(got), 32'd1);
      check({tag, "_latency"}, lat, 32'd3);
      check({tag, "_err"}, 32'(bus.err), 32'(exp_e));
      check({tag, "_data"}, bus.ram_data_into_mcu, exp_d);
      obs = bus.ram_data_into_mcu;
      @(negedge clk);
      check({tag, "_pulse"}, 32'(bus.ram_ready), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] obs;
      logic [31:0] exp_b2b;
      logic [31:0] addr;
      logic [1:0]  size;
      bit          exp_e;
      int          kind;

      rst = 1'b0; rst0 = 1'b0;
      scramble();
      bus0.cs = 1'b0; bus0.we = 1'b0; bus0.oe = 1'b0;
      bus0.address = 32'd0; bus0.data_size = 2'd0; bus0.ram_data_in = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.ram_ready), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_data", bus.ram_data_into_mcu, 32'd0);
      rst = 1'b1; rst0 = 1'b1;

      for (int w = 0; w < 16; w++) begin
         run_access("init_wr", 1'b1, 1'b0, 32'(4 * w), 2'b10, $urandom, obs);
      end

      run_access("word_wr", 1'b1, 1'b0, 32'h10, 2'b10, 32'hDEADBEEF, obs);
      run_access("word_rd", 1'b0, 1'b1, 32'h10, 2'b10, 32'h0, obs);
      check("word_rd_const", obs, 32'hDEADBEEF);

      run_access("byte_wr", 1'b1, 1'b0, 32'h13, 2'b00, 32'hFFFF_FFAB, obs);
      run_access("lane_word_rd", 1'b0, 1'b1, 32'h10, 2'b10, 32'h0, obs);
      check("lane_word_const", obs, 32'hABADBEEF);
      run_access("lane_half_rd", 1'b0, 1'b1, 32'h12, 2'b01, 32'h0, obs);
      check("lane_half_const", obs, 32'h0000ABAD);
      run_access("lane_byte_rd", 1'b0, 1'b1, 32'h11, 2'b00, 32'h0, obs);
      check("lane_byte_const", obs, 32'h000000BE);

      run_access("ill_word_wr", 1'b1, 1'b0, 32'h11, 2'b10, 32'h11111111, obs);
      run_access("ill_half_rd", 1'b0, 1'b1, 32'h13, 2'b01, 32'h0, obs);
      run_access("ill_size3", 1'b0, 1'b1, 32'h10, 2'b11, 32'h0, obs);
      run_access("ill_range", 1'b1, 1'b0, 32'h1000, 2'b10, 32'h22222222, obs);
      run_access("ill_weoe", 1'b1, 1'b1, 32'h10, 2'b10, 32'h33333333, obs);
      run_access("ill_after_rd", 1'b0, 1'b1, 32'h10, 2'b10, 32'h0, obs);
      check("ill_after_const", obs, 32'hABADBEEF);

      // Back-to-back reads with cs held: pulses every WAIT_STATES+2 cycles.
      model_access(1'b0, 1'b1, 32'h10, 2'b10, 32'h0, exp_b2b, exp_e);
      @(negedge clk);
      bus.cs = 1'b1; bus.we = 1'b0; bus.oe = 1'b1;
      bus.address = 32'h10; bus.data_size = 2'b10; bus.ram_data_in = 32'h0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check("b2b_ready", 32'(bus.ram_ready), 32'((k == 3) || (k == 7) || (k == 11)));
         if (k == 3 || k == 7 || k == 11) check("b2b_data", bus.ram_data_into_mcu, exp_b2b);
      end
      bus.cs = 1'b0;

      @(negedge clk);
      bus0.cs = 1'b1; bus0.we = 1'b1; bus0.oe = 1'b0;
      bus0.address = 32'h10; bus0.data_size = 2'b10; bus0.ram_data_in = 32'h5A5AC3C3;
      @(posedge clk);
      #1 bus0.cs = 1'b0; bus0.ram_data_in = 32'hFFFFFFFF;
      @(negedge clk);
      check("ws0_wr_ready", 32'(bus0.ram_ready), 32'd1);
      check("ws0_wr_err", 32'(bus0.err), 32'd0);
      @(negedge clk);
      check("ws0_wr_pulse", 32'(bus0.ram_ready), 32'd0);
      bus0.cs = 1'b1; bus0.we = 1'b0; bus0.oe = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check("ws0_b2b_ready", 32'(bus0.ram_ready), 32'((k % 2) == 1 && k <= 5));
         if ((k % 2) == 1) check("ws0_b2b_data", bus0.ram_data_into_mcu, 32'h5A5AC3C3);
      end
      bus0.cs = 1'b0;

      // Reset during WAIT aborts the pending write.
      run_access("rst_pre_wr", 1'b1, 1'b0, 32'h20, 2'b10, 32'h0BADF00D, obs);
      run_access("rst_pre_rd", 1'b0, 1'b1, 32'h20, 2'b10, 32'h0, obs);
      @(negedge clk);
      bus.cs = 1'b1; bus.we = 1'b1; bus.oe = 1'b0;
      bus.address = 32'h20; bus.data_size = 2'b10; bus.ram_data_in = 32'h12345678;
      @(posedge clk);
      #1 scramble();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_data", bus.ram_data_into_mcu, 32'd0);
      check("midrst_ready", 32'(bus.ram_ready), 32'd0);
      check("midrst_err", 32'(bus.err), 32'd0);
      last_data = 32'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("midrst_hold_ready", 32'(bus.ram_ready), 32'd0);
      end
      rst = 1'b1;
      run_access("midrst_rd", 1'b0, 1'b1, 32'h20, 2'b10, 32'h0, obs);
      check("midrst_rd_const", obs, 32'h0BADF00D);

      run_access("latch_wr", 1'b1, 1'b0, 32'h10, 2'b10, 32'hCAFEF00D, obs);
      run_access("latch_rd", 1'b0, 1'b1, 32'h10, 2'b10, 32'h0, obs);
      check("latch_rd_const", obs, 32'hCAFEF00D);

      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 9);
         size = 2'($urandom_range(0, 2));
         addr = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
         case (kind)
            0: run_access("rnd_weoe", 1'b1, 1'b1, addr, size, $urandom, obs);
            1: run_access("rnd_range", 1'($urandom), 1'b1, 32'h1000 + addr, size, $urandom, obs);
            2: run_access("rnd_size3", 1'b0, 1'b1, addr, 2'b11, $urandom, obs);
            default: begin
               if ($urandom_range(0, 1) == 1) run_access("rnd_wr", 1'b1, 1'b0, addr, size, $urandom, obs);
               else run_access("rnd_rd", 1'b0, 1'b1, addr, size, 32'h0, obs);
            end
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
